// File: rtl/audio_ctrl_pkg.sv
// Shared types for the audio recorder/player sequencer: state encoding and default widths.
package audio_ctrl_pkg;

  localparam int ADDR_W  = 20;
  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE       = 3'd0,
    S_REC        = 3'd1,
    S_REC_PAUSE  = 3'd2,
    S_PLAY       = 3'd3,
    S_PLAY_PAUSE = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/audio_ctrl_fsm.sv
// Top-level record/play sequencer: turns key pulses into registered one-cycle commands,
// tracks the end-of-recording address and hands the single SRAM port to the active side.
module audio_ctrl_fsm #(
  parameter int                ADDR_W   = audio_ctrl_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}}
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_key_rec,
  input  logic                                i_key_play,
  input  logic                                i_key_stop,
  input  logic [ADDR_W-1:0]                   i_rec_addr,
  input  logic                                i_rec_wr,
  input  logic [15:0]                         i_rec_data,
  input  logic [ADDR_W-1:0]                   i_dsp_addr,
  output logic                                o_rec_start,
  output logic                                o_rec_pause,
  output logic                                o_rec_stop,
  output logic                                o_dsp_start,
  output logic                                o_dsp_pause,
  output logic                                o_dsp_stop,
  output logic [ADDR_W-1:0]                   o_sram_addr,
  output logic                                o_sram_we_n,
  output logic [15:0]                         o_sram_wdata,
  output logic [ADDR_W-1:0]                   o_end_addr,
  output logic                                o_end_valid,
  output logic [audio_ctrl_pkg::STATE_W-1:0]  o_state
);
  import audio_ctrl_pkg::*;

  ctrl_state_t state;
  logic        wrote;       // at least one sample written since the current recording started
  logic        rec_wr_act;
  logic        rec_full;
  logic        play_done;

  assign rec_wr_act = (state == S_REC) && i_rec_wr;
  assign rec_full   = rec_wr_act && (i_rec_addr == MAX_ADDR);
  assign play_done  = (state == S_PLAY) && (i_dsp_addr > o_end_addr);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= S_IDLE;
      wrote       <= 1'b0;
      o_end_addr  <= '0;
      o_end_valid <= 1'b0;
      o_rec_start <= 1'b0;
      o_rec_pause <= 1'b0;
      o_rec_stop  <= 1'b0;
      o_dsp_start <= 1'b0;
      o_dsp_pause <= 1'b0;
      o_dsp_stop  <= 1'b0;
    end else begin
      o_rec_start <= 1'b0;
      o_rec_pause <= 1'b0;
      o_rec_stop  <= 1'b0;
      o_dsp_start <= 1'b0;
      o_dsp_pause <= 1'b0;
      o_dsp_stop  <= 1'b0;

      if (rec_wr_act) begin
        o_end_addr <= i_rec_addr;
        wrote      <= 1'b1;
      end

      // Auto-stop conditions are checked ahead of keys; among keys stop > rec > play.
      case (state)
        S_IDLE: begin
          if (i_key_rec) begin
            state       <= S_REC;
            o_rec_start <= 1'b1;
            o_end_valid <= 1'b0;
            wrote       <= 1'b0;
          end else if (i_key_play && o_end_valid) begin
            state       <= S_PLAY;
            o_dsp_start <= 1'b1;
          end
        end
        S_REC: begin
          if (rec_full || i_key_stop) begin
            state       <= S_IDLE;
            o_rec_stop  <= 1'b1;
            o_end_valid <= wrote || i_rec_wr;
          end else if (i_key_rec) begin
            state       <= S_REC_PAUSE;
            o_rec_pause <= 1'b1;
          end
        end
        S_REC_PAUSE: begin
          if (i_key_stop) begin
            state       <= S_IDLE;
            o_rec_stop  <= 1'b1;
            o_end_valid <= wrote;
          end else if (i_key_rec) begin
            state       <= S_REC;
            o_rec_start <= 1'b1;
          end
        end
        S_PLAY: begin
          if (play_done || i_key_stop) begin
            state      <= S_IDLE;
            o_dsp_stop <= 1'b1;
          end else if (i_key_play) begin
            state       <= S_PLAY_PAUSE;
            o_dsp_pause <= 1'b1;
          end
        end
        S_PLAY_PAUSE: begin
          if (i_key_stop) begin
            state      <= S_IDLE;
            o_dsp_stop <= 1'b1;
          end else if (i_key_play) begin
            state       <= S_PLAY;
            o_dsp_start <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // SRAM port follows the current state with no added latency; paused recording never writes.
  always_comb begin
    o_sram_addr  = i_dsp_addr;
    o_sram_we_n  = 1'b1;
    o_sram_wdata = 16'h0000;
    if (state == S_REC || state == S_REC_PAUSE) begin
      o_sram_addr  = i_rec_addr;
      o_sram_we_n  = ~rec_wr_act;
      o_sram_wdata = i_rec_data;
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_audio_ctrl_fsm.sv
// Directed scenarios plus random key/strobe traffic, checked against a transition-table model.
module tb_audio_ctrl_fsm;

  localparam logic [19:0] MAXA = 20'hFFFFF;
  // Pulse vector order: {rec_start, rec_pause, rec_stop, dsp_start, dsp_pause, dsp_stop}
  localparam logic [5:0] P_RSTART = 6'b100000, P_RPAUSE = 6'b010000, P_RSTOP = 6'b001000;
  localparam logic [5:0] P_DSTART = 6'b000100, P_DPAUSE = 6'b000010, P_DSTOP = 6'b000001;
  localparam int K_STOP = 0, K_REC = 1, K_PLAY = 2;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_key_rec, i_key_play, i_key_stop;
  logic [19:0] i_rec_addr, i_dsp_addr;
  logic        i_rec_wr;
  logic [15:0] i_rec_data;
  logic        o_rec_start, o_rec_pause, o_rec_stop;
  logic        o_dsp_start, o_dsp_pause, o_dsp_stop;
  logic [19:0] o_sram_addr, o_end_addr;
  logic        o_sram_we_n, o_end_valid;
  logic [15:0] o_sram_wdata;
  logic [2:0]  o_state;

  audio_ctrl_fsm dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_key_rec(i_key_rec), .i_key_play(i_key_play), .i_key_stop(i_key_stop),
    .i_rec_addr(i_rec_addr), .i_rec_wr(i_rec_wr), .i_rec_data(i_rec_data),
    .i_dsp_addr(i_dsp_addr),
    .o_rec_start(o_rec_start), .o_rec_pause(o_rec_pause), .o_rec_stop(o_rec_stop),
    .o_dsp_start(o_dsp_start), .o_dsp_pause(o_dsp_pause), .o_dsp_stop(o_dsp_stop),
    .o_sram_addr(o_sram_addr), .o_sram_we_n(o_sram_we_n), .o_sram_wdata(o_sram_wdata),
    .o_end_addr(o_end_addr), .o_end_valid(o_end_valid), .o_state(o_state)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;
  int we_low   = 0;
  int pulse_cnt [6];

  // Reference model: states numbered IDLE=0 REC=1 REC_PAUSE=2 PLAY=3 PLAY_PAUSE=4
  int          m_state;
  logic [19:0] m_end_addr;
  bit          m_end_valid;
  bit          m_wrote;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] dut_pulses();
    return {o_rec_start, o_rec_pause, o_rec_stop, o_dsp_start, o_dsp_pause, o_dsp_stop};
  endfunction

  // Which key moves which state where; returns 0 when the key has no effect there.
  function automatic bit key_edge(input int s, input int k, input bit ev,
                                  output int nxt, output logic [5:0] p);
    nxt = s; p = '0;
    case ({s[3:0], k[3:0]})
      {4'd0, 4'd1}: begin nxt = 1; p = P_RSTART; end
      {4'd0, 4'd2}: if (ev) begin nxt = 3; p = P_DSTART; end else return 0;
      {4'd1, 4'd1}: begin nxt = 2; p = P_RPAUSE; end
      {4'd2, 4'd1}: begin nxt = 1; p = P_RSTART; end
      {4'd1, 4'd0}, {4'd2, 4'd0}: begin nxt = 0; p = P_RSTOP; end
      {4'd3, 4'd2}: begin nxt = 4; p = P_DPAUSE; end
      {4'd4, 4'd2}: begin nxt = 3; p = P_DSTART; end
      {4'd3, 4'd0}, {4'd4, 4'd0}: begin nxt = 0; p = P_DSTOP; end
      default: return 0;
    endcase
    return 1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_end_addr = '0; m_end_valid = 0; m_wrote = 0;
  endtask

  task automatic model_step(input bit kr, input bit kp, input bit ks, input bit wr,
                            input logic [19:0] ra, input logic [19:0] da,
                            output logic [5:0] p);
    int  nxt;
    bit  writing, wrote_now, hit;
    bit  keys [3];
    writing   = (m_state == 1) && wr;
    wrote_now = m_wrote || writing;
    nxt = m_state; p = '0;
    keys[K_STOP] = ks; keys[K_REC] = kr; keys[K_PLAY] = kp;
    if (writing && ra == MAXA) begin
      nxt = 0; p = P_RSTOP;
    end else if (m_state == 3 && da > m_end_addr) begin
      nxt = 0; p = P_DSTOP;
    end else begin
      hit = 0;
      for (int k = 0; k < 3; k++)
        if (!hit && keys[k]) hit = key_edge(m_state, k, m_end_valid, nxt, p);
    end
    if (writing) m_end_addr = ra;
    if (m_state == 0 && nxt == 1) begin
      m_end_valid = 0; m_wrote = 0;
    end else begin
      if ((m_state == 1 || m_state == 2) && nxt == 0) m_end_valid = wrote_now;
      m_wrote = wrote_now;
    end
    m_state = nxt;
  endtask

  // One clock: drive inputs, check the combinational SRAM port, then the registered outputs.
  task automatic step(input bit kr, input bit kp, input bit ks, input bit wr,
                      input logic [19:0] ra, input logic [15:0] rd, input logic [19:0] da);
    logic [5:0]  p;
    logic [19:0] e_addr;
    logic [15:0] e_wdata;
    bit          e_we_n;
    i_key_rec = kr; i_key_play = kp; i_key_stop = ks;
    i_rec_wr = wr; i_rec_addr = ra; i_rec_data = rd; i_dsp_addr = da;
    #1;
    if (m_state == 1 || m_state == 2) begin
      e_addr = ra; e_wdata = rd; e_we_n = !(m_state == 1 && wr);
    end else begin
      e_addr = da; e_wdata = '0; e_we_n = 1'b1;
    end
    chk("sram_addr", o_sram_addr, e_addr);
    chk("sram_we_n", o_sram_we_n, e_we_n);
    chk("sram_wdata", o_sram_wdata, e_wdata);
    if (!o_sram_we_n) we_low++;
    model_step(kr, kp, ks, wr, ra, da, p);
    @(posedge i_clk);
    #1;
    chk("state", o_state, m_state);
    chk("pulses", dut_pulses(), p);
    chk("end_addr", o_end_addr, m_end_addr);
    chk("end_valid", o_end_valid, m_end_valid);
    for (int i = 0; i < 6; i++) if (p[5-i]) pulse_cnt[i]++;
    i_key_rec = 0; i_key_play = 0; i_key_stop = 0; i_rec_wr = 0;
  endtask

  task automatic clear_counts();
    we_low = 0;
    for (int i = 0; i < 6; i++) pulse_cnt[i] = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_state"}, o_state, 0);
    chk({tag, "_pulses"}, dut_pulses(), 6'b0);
    chk({tag, "_end_addr"}, o_end_addr, 0);
    chk({tag, "_end_valid"}, o_end_valid, 0);
    chk({tag, "_we_n"}, o_sram_we_n, 1);
    chk({tag, "_wdata"}, o_sram_wdata, 0);
    chk({tag, "_sram_addr"}, o_sram_addr, i_dsp_addr);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    model_reset();
    check_reset_outputs("reset");
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    bit          kr, kp, ks, wr;
    logic [19:0] ra;
    i_rst = 1'b1;
    i_key_rec = 0; i_key_play = 0; i_key_stop = 0;
    i_rec_wr = 0; i_rec_addr = '0; i_rec_data = '0; i_dsp_addr = 20'h00123;
    do_reset();

    // Record five samples then stop.
    clear_counts();
    step(1, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < 5; a++) step(0, 0, 0, 1, 20'(a), 16'(16'hA000 + a), 0);
    step(0, 0, 1, 0, 4, 0, 0);
    chk("rec_we_low_cycles", we_low, 5);
    chk("rec_start_count", pulse_cnt[0], 1);
    chk("rec_stop_count", pulse_cnt[2], 1);
    chk("rec_end_addr", o_end_addr, 20'd4);
    chk("rec_end_valid", o_end_valid, 1);

    // Play back until the reader passes the last recorded address.
    clear_counts();
    step(0, 1, 0, 0, 0, 0, 0);
    for (int a = 0; a <= 5; a++) step(0, 0, 0, 0, 0, 0, 20'(a));
    chk("play_dsp_start_count", pulse_cnt[3], 1);
    chk("play_dsp_stop_count", pulse_cnt[5], 1);
    chk("play_we_low_cycles", we_low, 0);
    chk("play_end_state", o_state, 0);

    // Play / pause / resume with a stray recorder write strobe.
    step(0, 1, 0, 1, 7, 16'h5555, 0);
    step(0, 1, 0, 1, 7, 16'h5555, 1);
    step(0, 1, 0, 1, 7, 16'h5555, 1);
    chk("resume_state", o_state, 3);
    step(0, 0, 1, 1, 7, 16'h5555, 2);

    // Play refused without a recording; rec+stop together in REC gives only a stop.
    do_reset();
    step(0, 1, 0, 0, 0, 0, 0);
    chk("play_ignored_state", o_state, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0, 0);
    chk("rec_stop_prio_state", o_state, 0);

    // Recording runs into the top of memory.
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, MAXA - 20'd2, 16'h1111, 0);
    step(0, 0, 0, 1, MAXA - 20'd1, 16'h2222, 0);
    step(0, 0, 0, 1, MAXA, 16'h3333, 0);
    chk("max_end_addr", o_end_addr, MAXA);
    step(0, 0, 0, 1, MAXA, 16'h4444, 0);

    // Reset in PLAY_PAUSE takes effect immediately.
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 3);
    chk("pp_state", o_state, 4);
    i_dsp_addr = 20'h0ABCD;
    #2 i_rst = 1'b1;
    #1;
    model_reset();
    check_reset_outputs("mid_reset");
    @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    // Random traffic.
    ra = '0;
    for (int n = 0; n < 600; n++) begin
      kr = ($urandom_range(0, 7) == 0);
      kp = ($urandom_range(0, 5) == 0);
      ks = ($urandom_range(0, 11) == 0);
      wr = $urandom_range(0, 1);
      if ($urandom_range(0, 63) == 0) ra = MAXA - 20'($urandom_range(0, 2));
      step(kr, kp, ks, wr, ra, 16'($urandom), 20'($urandom_range(0, 40)));
      if (wr) ra = ra + 20'd1;
      if (ra > 20'd30 && ra < 20'hFFF00) ra = '0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_ctrl_fsm.md
# audio_ctrl_fsm

Top-level sequencer for the audio recorder/player. It turns debounced key pulses into single-cycle start/pause/stop commands for the recorder and for `AudDSP`, and gives the single external SRAM port to whichever one is active. It also latches the end-of-recording address and stops playback automatically when that address is passed. It sits between the key debouncers, `AudRecorder`, `AudDSP` and the SRAM pins.

## Interface
Parameters:
- `ADDR_W`, default 20: SRAM word-address width.
- `MAX_ADDR`, default 20'hFFFFF: last writable SRAM address.

Ports:
- `i_clk` in 1: system clock; every register is clocked on its rising edge.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_key_rec`, `i_key_play`, `i_key_stop` in 1 each: key pulses, already debounced, exactly one cycle high.
- `i_rec_addr` in ADDR_W: write address from the recorder.
- `i_rec_wr` in 1: recorder write strobe, one cycle per sample.
- `i_rec_data` in 16: sample from the recorder.
- `i_dsp_addr` in ADDR_W: read address from `AudDSP` (its `o_sram_addr`).
- `o_rec_start`, `o_rec_pause`, `o_rec_stop` out 1 each: recorder command pulses.
- `o_dsp_start`, `o_dsp_pause`, `o_dsp_stop` out 1 each: `AudDSP` command pulses.
- `o_sram_addr` out ADDR_W, `o_sram_we_n` out 1, `o_sram_wdata` out 16: SRAM port.
- `o_end_addr` out ADDR_W: last recorded address.
- `o_end_valid` out 1: a recording exists.
- `o_state` out 3: current state, for the 7-segment display.

## Operation
States and their `o_state` encoding: IDLE=0, REC=1, REC_PAUSE=2, PLAY=3, PLAY_PAUSE=4.

Key priority when keys arrive in the same cycle: stop > rec > play. A key with no transition in the current state is ignored.

Transitions (each command pulse is listed on the transition that produces it):
- IDLE + rec → REC; pulse `o_rec_start`. This clears `o_end_valid`.
- IDLE + play with `o_end_valid`=1 → PLAY; pulse `o_dsp_start`. Play with `o_end_valid`=0 is ignored.
- REC + rec → REC_PAUSE; pulse `o_rec_pause`.
- REC_PAUSE + rec → REC; pulse `o_rec_start`.
- REC or REC_PAUSE + stop → IDLE; pulse `o_rec_stop`.
- PLAY + play → PLAY_PAUSE; pulse `o_dsp_pause`.
- PLAY_PAUSE + play → PLAY; pulse `o_dsp_start`.
- PLAY or PLAY_PAUSE + stop → IDLE; pulse `o_dsp_stop`.
- REC with `i_rec_wr`=1 and `i_rec_addr`==MAX_ADDR: the write completes. Next state is IDLE, with `o_rec_stop` pulsed.
- PLAY with `i_dsp_addr` > `o_end_addr`: auto-stop. Next state is IDLE, with `o_dsp_stop` pulsed.
- An auto-stop and a key in the same cycle: the auto-stop wins.

End address:
- On every `i_rec_wr` in REC, `o_end_addr` ← `i_rec_addr`.
- `o_end_valid` is set on the transition REC/REC_PAUSE → IDLE, but only if at least one write occurred during the recording.

SRAM arbitration (combinational mux on the current state):
- REC and REC_PAUSE: `o_sram_addr`=`i_rec_addr`, `o_sram_we_n`=~`i_rec_wr`, `o_sram_wdata`=`i_rec_data`.
- All other states: `o_sram_addr`=`i_dsp_addr`, `o_sram_we_n`=1, `o_sram_wdata`=0.
- In REC_PAUSE the write strobe is forced off: `o_sram_we_n`=1 regardless of `i_rec_wr`.

## Timing
- Reset values: state IDLE; all command pulses 0; `o_end_addr` 0; `o_end_valid` 0; `o_sram_we_n` 1; `o_sram_wdata` 0; `o_sram_addr`=`i_dsp_addr` (mux transparent).
- Key latency: a key sampled at edge N updates the state and raises the registered command pulse after edge N. The pulse is exactly one cycle wide.
- SRAM outputs: zero latency from inputs and state.
- An auto-stop condition present at edge N gives IDLE and the stop pulse after edge N. Writes after that edge are blocked.
- Reset asserted mid-operation: the state returns to IDLE asynchronously. No stop pulse is emitted; the downstream blocks share the same reset. The end address is lost.

## Structure
- Package `audio_ctrl_pkg` holds:
  - enum `ctrl_state_t` with the five states;
  - `ADDR_W`;
  - the width of `o_state`.
- Single module; no sub-module is needed. The command-pulse register bank may stay inline.

## Test plan
- Reset, then rec pulse, then 5 `i_rec_wr` at addresses 0..4, then stop → `o_rec_start` and `o_rec_stop` each pulse once; `o_end_addr`=4; `o_end_valid`=1; `o_state` goes 0→1→0; `o_sram_we_n` is low on exactly 5 cycles.
- Play after the recording above; drive `i_dsp_addr` 0..5 → `o_dsp_start` pulses once; `o_sram_we_n` stays 1; when `i_dsp_addr`=5 the state returns to 0 with one `o_dsp_stop` pulse.
- Play, play, play → states 3→4→3; pulses `o_dsp_start`, `o_dsp_pause`, `o_dsp_start`. An `i_rec_wr` asserted during playback keeps `o_sram_we_n`=1.
- Play key pressed with `o_end_valid`=0 right after reset → state stays 0, no pulse. Rec and stop in the same cycle while in REC → IDLE with `o_rec_stop` only.
- Recording reaches MAX_ADDR with `i_rec_wr` → exactly one more write; auto `o_rec_stop`; `o_end_addr`=FFFFF.
- Assert `i_rst` during PLAY_PAUSE → all outputs take their reset values immediately, with no command pulses.
